// File: rtl/m_memarb_pkg.sv
// m_memarb shared types: owner tags, FSM states and default widths.
// Widths match m_memory (4K x 32).
package m_memarb_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 32;
    localparam int ST_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } own_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/m_memarb_if.sv
// m_memarb bus: IF requester, MEM requester and memory command/return.
// slave = arbiter side, master = requesters plus memory.
interface m_memarb_if
    import m_memarb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic              w_i_req;
    logic [ADDR_W-1:0] w_i_addr;
    logic              r_i_gnt;
    logic              r_i_vld;
    logic [DATA_W-1:0] r_i_rdata;

    logic              w_d_req;
    logic              w_d_we;
    logic [ADDR_W-1:0] w_d_addr;
    logic [DATA_W-1:0] w_d_wdata;
    logic              r_d_gnt;
    logic              r_d_vld;
    logic [DATA_W-1:0] r_d_rdata;

    logic [ADDR_W-1:0] r_m_addr;
    logic              r_m_we;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] w_m_rdata;

    modport slave (
        input  w_i_req, w_i_addr,
        output r_i_gnt, r_i_vld, r_i_rdata,
        input  w_d_req, w_d_we, w_d_addr, w_d_wdata,
        output r_d_gnt, r_d_vld, r_d_rdata,
        output r_m_addr, r_m_we, r_m_wdata,
        input  w_m_rdata
    );

    modport master (
        output w_i_req, w_i_addr,
        input  r_i_gnt, r_i_vld, r_i_rdata,
        output w_d_req, w_d_we, w_d_addr, w_d_wdata,
        input  r_d_gnt, r_d_vld, r_d_rdata,
        input  r_m_addr, r_m_we, r_m_wdata,
        output w_m_rdata
    );

endinterface

// File: rtl/m_memarb_pick.sv
// m_memarb winner select; MEMARB_RR_EN picks round-robin on conflict,
// otherwise MEM has priority unless IF is starved.
module m_memarb_pick
    import m_memarb_pkg::*;
(
    input  logic       w_i_req,
    input  logic       w_d_req,
`ifdef MEMARB_RR_EN
    input  logic       w_last_mem,
`else
    input  logic       w_starve,
`endif
    input  state_e     w_state,
    output logic [1:0] r_gnt
);

    logic w_if_first;

`ifdef MEMARB_RR_EN
    assign w_if_first = w_last_mem;
`else
    assign w_if_first = w_starve;
`endif

    // r_gnt[0] = IF, r_gnt[1] = MEM
    always_comb begin
        r_gnt = 2'b00;
        unique case (w_state)
            ST_RUN: begin
                if (w_i_req && w_d_req)
                    r_gnt = w_if_first ? 2'b01 : 2'b10;
                else
                    r_gnt = {w_d_req, w_i_req};
            end
            ST_DRAIN: r_gnt = {w_d_req, 1'b0};
            default:  r_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/m_memarb.sv
// m_memarb: shares one 1-cycle-latency memory between IF and MEM.
// Build option MEMARB_RR_EN selects round-robin conflict arbitration.
module m_memarb
    import m_memarb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_memarb_if.slave   bus,
    input  logic        w_halt_req,
    output logic        r_halted,
    output logic [31:0] r_conf_cnt
);

    state_e            r_state;
    own_e              r_own;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_i_hold;
    logic [DATA_W-1:0] r_d_hold;
    logic              w_conf;

    assign w_conf = bus.w_i_req & bus.w_d_req;

`ifdef MEMARB_RR_EN
    logic r_last_mem;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_last_mem <= 1'b1;
        else if (w_conf && (|w_gnt))
            r_last_mem <= w_gnt[1];
    end
`else
    localparam logic [ST_W-1:0] STARVE_LIM = ST_W'(STARVE_MAX);

    logic [ST_W-1:0] r_starve;
    logic            w_starve;

    assign w_starve = (r_starve == STARVE_LIM);

    // Parks at the limit so a long drain cannot skip past the forced grant
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_starve <= '0;
        else if (!bus.w_i_req || w_gnt[0])
            r_starve <= '0;
        else if (!w_starve)
            r_starve <= r_starve + ST_W'(1);
    end
`endif

    m_memarb_pick u_pick (
        .w_i_req    (bus.w_i_req),
        .w_d_req    (bus.w_d_req),
`ifdef MEMARB_RR_EN
        .w_last_mem (r_last_mem),
`else
        .w_starve   (w_starve),
`endif
        .w_state    (r_state),
        .r_gnt      (w_gnt)
    );

    assign bus.r_i_gnt = w_gnt[0];
    assign bus.r_d_gnt = w_gnt[1];

    always_comb begin
        bus.r_m_addr  = r_addr_q;
        bus.r_m_we    = 1'b0;
        bus.r_m_wdata = '0;
        if (w_gnt[0]) begin
            bus.r_m_addr = bus.w_i_addr;
        end else if (w_gnt[1]) begin
            bus.r_m_addr  = bus.w_d_addr;
            bus.r_m_we    = bus.w_d_we;
            bus.r_m_wdata = bus.w_d_wdata;
        end
    end

    assign bus.r_i_vld   = (r_own == OWN_IF);
    assign bus.r_d_vld   = (r_own == OWN_MEM);
    assign bus.r_i_rdata = bus.r_i_vld ? bus.w_m_rdata : r_i_hold;
    assign bus.r_d_rdata = bus.r_d_vld ? bus.w_m_rdata : r_d_hold;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_own      <= OWN_NONE;
            r_addr_q   <= '0;
            r_i_hold   <= '0;
            r_d_hold   <= '0;
            r_conf_cnt <= '0;
        end else begin
            r_addr_q <= bus.r_m_addr;
            if (bus.r_i_vld)
                r_i_hold <= bus.w_m_rdata;
            if (bus.r_d_vld)
                r_d_hold <= bus.w_m_rdata;
            if (w_gnt[0])
                r_own <= OWN_IF;
            else if (w_gnt[1] && !bus.w_d_we)
                r_own <= OWN_MEM;
            else
                r_own <= OWN_NONE;
            if (w_conf && (r_conf_cnt != 32'hFFFF_FFFF))
                r_conf_cnt <= r_conf_cnt + 32'd1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_halt_req)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!w_halt_req) begin
                        r_state <= ST_RUN;
                    end else if (!bus.w_d_req && r_own == OWN_NONE) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!w_halt_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_memarb.sv
// Bench for m_memarb: directed vector table, halt and reset sequences,
// then random traffic against a cycle-level reference model.
module tb_m_memarb;

    localparam int SMAX = 4;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic        w_halt_req;
    logic        r_halted;
    logic [31:0] r_conf_cnt;

    m_memarb_if bus ();

    m_memarb #(.STARVE_MAX(SMAX)) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .bus        (bus),
        .w_halt_req (w_halt_req),
        .r_halted   (r_halted),
        .r_conf_cnt (r_conf_cnt)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] init_word(input int a);
        logic [11:0] lo;
        lo = a[11:0];
        case (a)
            0:       return 32'h0000_0020;
            1:       return 32'h2009_0000;
            2:       return 32'h200A_0000;
            3:       return 32'h0000_0033;
            4:       return 32'h0000_0044;
            default: return {20'hABCDE, lo};
        endcase
    endfunction

    // Single-port memory, registered read; preloaded on the first edge
    logic [31:0] mem [4096];
    logic [31:0] mem_q;
    bit          loaded = 1'b0;

    always @(posedge w_clk) begin
        if (!loaded) begin
            for (int k = 0; k < 4096; k++)
                mem[k] <= init_word(k);
            loaded <= 1'b1;
        end else if (bus.r_m_we) begin
            mem[bus.r_m_addr] <= bus.r_m_wdata;
        end
        mem_q <= mem[bus.r_m_addr];
    end

    assign bus.w_m_rdata = mem_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [11:0] ia,
                         input logic dr, input logic dw,
                         input logic [11:0] da, input logic [31:0] dd,
                         input logic h);
        @(negedge w_clk);
        bus.w_i_req   = ir;
        bus.w_i_addr  = ia;
        bus.w_d_req   = dr;
        bus.w_d_we    = dw;
        bus.w_d_addr  = da;
        bus.w_d_wdata = dd;
        w_halt_req    = h;
        #2;
    endtask

    typedef struct {
        logic        ir;
        logic [11:0] ia;
        logic        dr;
        logic        dw;
        logic [11:0] da;
        logic [31:0] dd;
        logic        eig;
        logic        edg;
        logic        eiv;
        logic        edv;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ir, input logic [11:0] ia,
                       input logic dr, input logic dw,
                       input logic [11:0] da, input logic [31:0] dd,
                       input logic eig, input logic edg,
                       input logic eiv, input logic edv,
                       input logic [31:0] erd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
        v.da = da; v.dd = dd;
        v.eig = eig; v.edg = edg;
        v.eiv = eiv; v.edv = edv; v.erd = erd;
        tbl.push_back(v);
    endtask

    // Who wins the k-th cycle of a held conflict starting from a clean slate
    function automatic logic conf_if_wins(input int k);
`ifdef MEMARB_RR_EN
        return (k % 2) == 0;
`else
        return (k % (SMAX + 1)) == SMAX;
`endif
    endfunction

    logic [31:0] ref_mem [4096];

    initial begin
        int          mode;
        int          streak;
        int          pend;
        bit          last_if;
        bit          h;
        logic [31:0] pdata, ih, dh, conf;
        logic [11:0] laddr;
        logic        ir, dr, dw, ig, dg, pw;
        logic [11:0] ia, da, eaddr;
        logic [31:0] dd;

        w_rst_n       = 1'b0;
        w_halt_req    = 1'b0;
        bus.w_i_req   = 1'b0;
        bus.w_i_addr  = '0;
        bus.w_d_req   = 1'b0;
        bus.w_d_we    = 1'b0;
        bus.w_d_addr  = '0;
        bus.w_d_wdata = '0;

        repeat (3) @(negedge w_clk);
        #2;
        chk("rst_i_gnt", bus.r_i_gnt, 0);
        chk("rst_d_gnt", bus.r_d_gnt, 0);
        chk("rst_i_vld", bus.r_i_vld, 0);
        chk("rst_d_vld", bus.r_d_vld, 0);
        chk("rst_m_we", bus.r_m_we, 0);
        chk("rst_halted", r_halted, 0);
        chk("rst_conf", r_conf_cnt, 0);
        @(negedge w_clk);
        w_rst_n = 1'b1;

        // IF-only fetch of three words
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0000_0020);
        add(1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 32'h2009_0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200A_0000);
        // Ten cycles of held conflict: IF at 0, MEM load at 4
        for (int k = 0; k < 10; k++) begin
            logic pi, ci;
            ci = conf_if_wins(k);
            pi = (k > 0) ? conf_if_wins(k - 1) : 1'b0;
            add(1, 0, 1, 0, 4, 0, ci, !ci,
                (k > 0) && pi, (k > 0) && !pi,
                pi ? 32'h0000_0020 : 32'h0000_0044);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, conf_if_wins(9), !conf_if_wins(9),
            conf_if_wins(9) ? 32'h0000_0020 : 32'h0000_0044);
        // Store then load of address 5
        add(0, 0, 1, 1, 5, 32'h1234, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].ir, tbl[n].ia, tbl[n].dr, tbl[n].dw,
                  tbl[n].da, tbl[n].dd, 0);
            chk($sformatf("tbl%0d_i_gnt", n), bus.r_i_gnt, tbl[n].eig);
            chk($sformatf("tbl%0d_d_gnt", n), bus.r_d_gnt, tbl[n].edg);
            chk($sformatf("tbl%0d_i_vld", n), bus.r_i_vld, tbl[n].eiv);
            chk($sformatf("tbl%0d_d_vld", n), bus.r_d_vld, tbl[n].edv);
            chk($sformatf("tbl%0d_m_we", n), bus.r_m_we,
                tbl[n].edg && tbl[n].dw);
            if (tbl[n].eiv)
                chk($sformatf("tbl%0d_i_rdata", n), bus.r_i_rdata, tbl[n].erd);
            if (tbl[n].edv)
                chk($sformatf("tbl%0d_d_rdata", n), bus.r_d_rdata, tbl[n].erd);
        end
        chk("conf_cnt_10", r_conf_cnt, 10);

        // Halt while a MEM load is in flight
        drive(0, 0, 1, 0, 3, 0, 0);
        chk("halt_a_d_gnt", bus.r_d_gnt, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("halt_b_i_gnt", bus.r_i_gnt, 1);
        chk("halt_b_d_vld", bus.r_d_vld, 1);
        chk("halt_b_d_rdata", bus.r_d_rdata, 32'h33);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("halt_c_i_gnt", bus.r_i_gnt, 0);
        chk("halt_c_i_vld", bus.r_i_vld, 1);
        chk("halt_c_halted", r_halted, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("halt_d_i_gnt", bus.r_i_gnt, 0);
        chk("halt_d_halted", r_halted, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("halt_e_halted", r_halted, 1);
        chk("halt_e_i_gnt", bus.r_i_gnt, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("halt_f_halted", r_halted, 0);
        chk("halt_f_i_gnt", bus.r_i_gnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("halt_g_i_vld", bus.r_i_vld, 1);
        chk("halt_g_i_rdata", bus.r_i_rdata, 32'h2009_0000);

        // Asynchronous reset between a load grant and its return
        drive(0, 0, 1, 0, 4, 0, 0);
        chk("mrst_d_gnt", bus.r_d_gnt, 1);
        @(posedge w_clk);
        #1;
        bus.w_d_req = 1'b0;
        w_rst_n     = 1'b0;
        #1;
        chk("mrst_d_vld", bus.r_d_vld, 0);
        chk("mrst_i_vld", bus.r_i_vld, 0);
        chk("mrst_d_rdata", bus.r_d_rdata, 0);
        chk("mrst_i_rdata", bus.r_i_rdata, 0);
        chk("mrst_m_addr", bus.r_m_addr, 0);
        chk("mrst_m_we", bus.r_m_we, 0);
        chk("mrst_conf", r_conf_cnt, 0);
        chk("mrst_halted", r_halted, 0);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("mrst_after_d_vld", bus.r_d_vld, 0);
            chk("mrst_after_i_vld", bus.r_i_vld, 0);
        end

        // Random traffic against the reference model
        for (int k = 16; k < 32; k++)
            ref_mem[k] = init_word(k);
        mode = 0; streak = 0; pend = 0; last_if = 1'b0; h = 1'b0;
        pdata = '0; ih = '0; dh = '0; conf = '0; laddr = '0;

        for (int n = 0; n < 400; n++) begin
            ir = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 4) < 3);
            dw = $urandom_range(0, 1);
            ia = 12'(16 + $urandom_range(0, 15));
            da = 12'(16 + $urandom_range(0, 15));
            dd = $urandom;
            if ($urandom_range(0, 15) == 0)
                h = !h;
            drive(ir, ia, dr, dw, da, dd, h);

            if (mode == 2) begin
                ig = 0; dg = 0;
            end else if (mode == 1) begin
                ig = 0; dg = dr;
            end else if (ir && dr) begin
`ifdef MEMARB_RR_EN
                ig = !last_if;
`else
                ig = (streak >= SMAX);
`endif
                dg = !ig;
            end else begin
                ig = ir; dg = dr;
            end
            eaddr = ig ? ia : (dg ? da : laddr);
            pw = dg && dw;

            chk("rnd_i_gnt", bus.r_i_gnt, ig);
            chk("rnd_d_gnt", bus.r_d_gnt, dg);
            chk("rnd_i_vld", bus.r_i_vld, pend == 1);
            chk("rnd_d_vld", bus.r_d_vld, pend == 2);
            chk("rnd_i_rdata", bus.r_i_rdata, (pend == 1) ? pdata : ih);
            chk("rnd_d_rdata", bus.r_d_rdata, (pend == 2) ? pdata : dh);
            chk("rnd_m_addr", bus.r_m_addr, eaddr);
            chk("rnd_m_we", bus.r_m_we, pw);
            if (pw)
                chk("rnd_m_wdata", bus.r_m_wdata, dd);
            chk("rnd_halted", r_halted, mode == 2);
            chk("rnd_conf", r_conf_cnt, conf);

            if (pend == 1) ih = pdata;
            if (pend == 2) dh = pdata;
            case (mode)
                0: if (h) mode = 1;
                1: begin
                    if (!h) mode = 0;
                    else if (!dr && pend == 0) mode = 2;
                end
                default: if (!h) mode = 0;
            endcase
            if (ig) begin
                pend = 1; pdata = ref_mem[ia];
            end else if (dg && !dw) begin
                pend = 2; pdata = ref_mem[da];
            end else begin
                pend = 0;
            end
            if (pw) ref_mem[da] = dd;
            if (ir && dr && conf != 32'hFFFF_FFFF) conf = conf + 1;
            if (ir && !ig) streak++;
            else streak = 0;
            if (ir && dr && (ig || dg)) last_if = ig;
            if (ig || dg) laddr = eaddr;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
